// File: rtl/y86_dmem_responder.sv
// Y86-64 data-memory responder: one 8-byte load/store at a time, fixed access latency, AOK/ADR status.
// Define DMEM_ALIGN_CHECK_EN to reject accesses whose address is not 8-byte aligned.
module y86_dmem_responder #(
    parameter int unsigned DEPTH_BYTES = 1024,
    parameter int unsigned LATENCY     = 2
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        req_valid_i,
    output logic        req_ready_o,
    input  logic        req_write_i,
    input  logic [63:0] req_addr_i,
    input  logic [63:0] req_wdata_i,
    output logic        rsp_valid_o,
    input  logic        rsp_ready_i,
    output logic [63:0] rsp_rdata_o,
    output logic [2:0]  rsp_stat_o
);
    localparam int unsigned AW       = $clog2(DEPTH_BYTES);
    localparam logic [63:0] MAX_ADDR = 64'(DEPTH_BYTES - 8);
    localparam logic [2:0]  STAT_AOK = 3'd1;
    localparam logic [2:0]  STAT_ADR = 3'd3;

    typedef enum logic [1:0] {S_IDLE, S_WAIT, S_RESP} state_e;

    state_e      state_q, state_d;
    logic [7:0]  cnt_q, cnt_d;
    logic        write_q, write_d;
    logic [63:0] addr_q, addr_d;
    logic [63:0] wdata_q, wdata_d;
    logic [63:0] rdata_q, rdata_d;
    logic [2:0]  stat_q, stat_d;
    logic [7:0]  mem_q [DEPTH_BYTES];

    logic          commit;
    logic          cmt_write;
    logic [63:0]   cmt_addr;
    logic [63:0]   cmt_wdata;
    logic [AW-1:0] cmt_idx;
    logic          cmt_err;
    logic [63:0]   ld_data;

    // With zero latency the commit happens on the accepting edge, so it must use the live request.
    assign cmt_write = (state_q == S_IDLE) ? req_write_i : write_q;
    assign cmt_addr  = (state_q == S_IDLE) ? req_addr_i  : addr_q;
    assign cmt_wdata = (state_q == S_IDLE) ? req_wdata_i : wdata_q;
    assign cmt_idx   = cmt_addr[AW-1:0];

    always_comb begin
        commit = 1'b0;
        if (!rst) begin
            if (state_q == S_IDLE)      commit = req_valid_i && (LATENCY == 0);
            else if (state_q == S_WAIT) commit = (cnt_q == 8'd0);
        end
    end

    always_comb begin
        cmt_err = (cmt_addr > MAX_ADDR);
`ifdef DMEM_ALIGN_CHECK_EN
        cmt_err = cmt_err | (cmt_addr[2:0] != 3'd0);
`endif
    end

    always_comb begin
        ld_data = '0;
        for (int i = 0; i < 8; i++) ld_data[8*i +: 8] = mem_q[cmt_idx + AW'(i)];
    end

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        write_d = write_q;
        addr_d  = addr_q;
        wdata_d = wdata_q;
        rdata_d = rdata_q;
        stat_d  = stat_q;
        case (state_q)
            S_IDLE: if (req_valid_i) begin
                write_d = req_write_i;
                addr_d  = req_addr_i;
                wdata_d = req_wdata_i;
                if (LATENCY == 0) begin
                    state_d = S_RESP;
                end else begin
                    state_d = S_WAIT;
                    cnt_d   = 8'(LATENCY - 1);
                end
            end
            S_WAIT: if (cnt_q == 8'd0) state_d = S_RESP;
                    else               cnt_d   = cnt_q - 8'd1;
            S_RESP: if (rsp_ready_i) state_d = S_IDLE;
            default: state_d = S_IDLE;
        endcase
        if (commit) begin
            rdata_d = (cmt_err || cmt_write) ? 64'd0 : ld_data;
            stat_d  = cmt_err ? STAT_ADR : STAT_AOK;
        end
    end

    // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= S_IDLE;
            cnt_q   <= 8'd0;
            write_q <= 1'b0;
            addr_q  <= 64'd0;
            wdata_q <= 64'd0;
            rdata_q <= 64'd0;
            stat_q  <= STAT_AOK;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            write_q <= write_d;
            addr_q  <= addr_d;
            wdata_q <= wdata_d;
            rdata_q <= rdata_d;
            stat_q  <= stat_d;
        end
    end

    // NOTE: the byte store has no reset; contents survive rst and are undefined until written.
    always_ff @(posedge clk) begin
        if (commit && cmt_write && !cmt_err) begin
            for (int i = 0; i < 8; i++) mem_q[cmt_idx + AW'(i)] <= cmt_wdata[8*i +: 8];
        end
    end

    always_comb begin
        req_ready_o = (state_q == S_IDLE);
        rsp_valid_o = (state_q == S_RESP);
    end

    assign rsp_rdata_o = rdata_q;
    assign rsp_stat_o  = stat_q;
endmodule

// File: tb/tb_y86_dmem_responder.sv
// Self-checking bench: instance A (LATENCY=2) runs the vector table and back-pressure test,
// instance B (LATENCY=4) runs the reset-during-WAIT sequence.
module tb_y86_dmem_responder;
    logic        clk = 1'b0;
    logic        rst_a = 1'b1, rst_b = 1'b1;
    logic        valid_a = 1'b0, valid_b = 1'b0;
    logic        req_write = 1'b0;
    logic [63:0] req_addr = '0, req_wdata = '0;
    logic        rsp_ready = 1'b1;
    logic        ready_a, ready_b, rvalid_a, rvalid_b;
    logic [63:0] rdata_a, rdata_b;
    logic [2:0]  stat_a, stat_b;

    int n_checks = 0;
    int n_pass   = 0;

    always #5 clk = ~clk;

    y86_dmem_responder #(.DEPTH_BYTES(1024), .LATENCY(2)) u_dut_a (
        .clk(clk), .rst(rst_a),
        .req_valid_i(valid_a), .req_ready_o(ready_a), .req_write_i(req_write),
        .req_addr_i(req_addr), .req_wdata_i(req_wdata),
        .rsp_valid_o(rvalid_a), .rsp_ready_i(rsp_ready),
        .rsp_rdata_o(rdata_a), .rsp_stat_o(stat_a)
    );

    y86_dmem_responder #(.DEPTH_BYTES(1024), .LATENCY(4)) u_dut_b (
        .clk(clk), .rst(rst_b),
        .req_valid_i(valid_b), .req_ready_o(ready_b), .req_write_i(req_write),
        .req_addr_i(req_addr), .req_wdata_i(req_wdata),
        .rsp_valid_o(rvalid_b), .rsp_ready_i(rsp_ready),
        .rsp_rdata_o(rdata_b), .rsp_stat_o(stat_b)
    );

    task automatic check(input string name, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got 0x%016h expected 0x%016h", name, got, exp);
    endtask

    // One request on instance A (b=0) or B (b=1); rsp_ready is assumed high.
    task automatic xact(input bit b, input bit wr, input logic [63:0] addr, input logic [63:0] wdata,
                        output logic [63:0] rd, output logic [2:0] st, output int lat);
        int guard;
        rd  = '0;
        st  = '0;
        lat = 0;
        @(negedge clk);
        guard = 0;
        while (!(b ? ready_b : ready_a) && guard < 50) begin
            @(negedge clk);
            guard++;
        end
        req_write = wr;
        req_addr  = addr;
        req_wdata = wdata;
        if (b) valid_b = 1'b1; else valid_a = 1'b1;
        @(posedge clk);
        #1;
        valid_a = 1'b0;
        valid_b = 1'b0;
        while (lat < 300) begin
            @(posedge clk);
            #1;
            lat++;
            if (b ? rvalid_b : rvalid_a) break;
        end
        rd = b ? rdata_b : rdata_a;
        st = b ? stat_b : stat_a;
        @(posedge clk);
        #1;
    endtask

    typedef struct {
        string       name;
        bit          wr;
        logic [63:0] addr;
        logic [63:0] wdata;
        logic [63:0] exp_rdata;
        logic [2:0]  exp_stat;
    } vec_t;

    vec_t vecs[12];

    initial begin
        logic [63:0] rd;
        logic [2:0]  st;
        int          lat;
        bit          saw_valid;

        vecs[0]  = '{"st_100",    1'b1, 64'h100, 64'h0123456789ABCDEF, 64'h0, 3'd1};
        vecs[1]  = '{"ld_100",    1'b0, 64'h100, 64'h0, 64'h0123456789ABCDEF, 3'd1};
        vecs[2]  = '{"st_108",    1'b1, 64'h108, 64'h0, 64'h0, 3'd1};
        vecs[3]  = '{"st_100b",   1'b1, 64'h100, 64'h0123456789ABCDEF, 64'h0, 3'd1};
`ifdef DMEM_ALIGN_CHECK_EN
        vecs[4]  = '{"ld_101",    1'b0, 64'h101, 64'h0, 64'h0, 3'd3};
`else
        vecs[4]  = '{"ld_101",    1'b0, 64'h101, 64'h0, 64'h000123456789ABCD, 3'd1};
`endif
        vecs[5]  = '{"st_3f8",    1'b1, 64'h3F8, 64'hDEADBEEFCAFEF00D, 64'h0, 3'd1};
        vecs[6]  = '{"ld_3f9",    1'b0, 64'h3F9, 64'h0, 64'h0, 3'd3};
        vecs[7]  = '{"ld_3f8",    1'b0, 64'h3F8, 64'h0, 64'hDEADBEEFCAFEF00D, 3'd1};
        vecs[8]  = '{"st_0",      1'b1, 64'h0, 64'h1122334455667788, 64'h0, 3'd1};
        vecs[9]  = '{"st_fffc",   1'b1, 64'hFFFF_FFFF_FFFF_FFFC, 64'hFFFF_FFFF_FFFF_FFFF, 64'h0, 3'd3};
        vecs[10] = '{"ld_0",      1'b0, 64'h0, 64'h0, 64'h1122334455667788, 3'd1};
        vecs[11] = '{"ld_400",    1'b0, 64'h400, 64'h0, 64'h0, 3'd3};

        // Reset both instances for two cycles
        repeat (2) @(posedge clk);
        #1;
        rst_a = 1'b0;
        rst_b = 1'b0;
        check("rst_req_ready", 64'(ready_a), 64'd1);
        check("rst_rsp_valid", 64'(rvalid_a), 64'd0);
        check("rst_rsp_stat",  64'(stat_a), 64'd1);
        check("rst_rsp_rdata", rdata_a, 64'd0);

        foreach (vecs[i]) begin
            xact(1'b0, vecs[i].wr, vecs[i].addr, vecs[i].wdata, rd, st, lat);
            check({vecs[i].name, "_lat"},   64'(lat), 64'd2);
            check({vecs[i].name, "_rdata"}, rd, vecs[i].exp_rdata);
            check({vecs[i].name, "_stat"},  64'(st), 64'(vecs[i].exp_stat));
            check({vecs[i].name, "_ready"}, 64'(ready_a), 64'd1);
        end

        // Back-pressure: hold the response of a load of 0x100 for 5 cycles
        @(negedge clk);
        rsp_ready = 1'b0;
        req_write = 1'b0;
        req_addr  = 64'h100;
        valid_a   = 1'b1;
        @(posedge clk);
        #1;
        req_addr = 64'h3F8;
        lat = 0;
        while (!rvalid_a && lat < 50) begin
            @(posedge clk);
            #1;
            lat++;
        end
        check("bp_lat", 64'(lat), 64'd2);
        for (int c = 0; c < 5; c++) begin
            @(posedge clk);
            #1;
            check("bp_valid", 64'(rvalid_a), 64'd1);
            check("bp_rdata", rdata_a, 64'h0123456789ABCDEF);
            check("bp_stat",  64'(stat_a), 64'd1);
            check("bp_ready", 64'(ready_a), 64'd0);
        end
        @(negedge clk);
        valid_a   = 1'b0;
        rsp_ready = 1'b1;
        @(posedge clk);
        #1;
        check("bp_done_valid", 64'(rvalid_a), 64'd0);
        check("bp_done_ready", 64'(ready_a), 64'd1);
        saw_valid = 1'b0;
        repeat (6) begin
            @(posedge clk);
            #1;
            if (rvalid_a) saw_valid = 1'b1;
        end
        check("bp_no_extra_rsp", 64'(saw_valid), 64'd0);

        // Reset during WAIT on the LATENCY=4 instance
        xact(1'b1, 1'b1, 64'h200, 64'h5555, rd, st, lat);
        check("b_init_lat",  64'(lat), 64'd4);
        check("b_init_stat", 64'(st), 64'd1);
        @(negedge clk);
        req_write = 1'b1;
        req_addr  = 64'h200;
        req_wdata = 64'hAAAA;
        valid_b   = 1'b1;
        @(posedge clk);
        #1;
        valid_b = 1'b0;
        check("b_wait_ready", 64'(ready_b), 64'd0);
        @(negedge clk);
        rst_b = 1'b1;
        @(posedge clk);
        #1;
        rst_b = 1'b0;
        check("b_rst_ready", 64'(ready_b), 64'd1);
        check("b_rst_valid", 64'(rvalid_b), 64'd0);
        saw_valid = 1'b0;
        repeat (8) begin
            @(posedge clk);
            #1;
            if (rvalid_b) saw_valid = 1'b1;
        end
        check("b_no_rsp", 64'(saw_valid), 64'd0);
        xact(1'b1, 1'b0, 64'h200, 64'h0, rd, st, lat);
        check("b_ld_rdata", rd, 64'h5555);
        check("b_ld_stat",  64'(st), 64'd1);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end
endmodule
